controlador_ventana_lectura: RTL and testbench

//  Upstream sequencer for the dynamic adder register. It walks a FILAS_VENTANA x COLUMNAS_VENTANA pixel window in image memory.
//  - Drives guardar/base to load the row-start address into that register.
//  - Pulses sumar to step the register by one row stride.
//  - Issues one handshaked memory read per window pixel, with a column offset.
//  - Signals listo when the whole window has been read.

---
 rtl/controlador_ventana_lectura_pkg.sv | 16 +
 rtl/controlador_ventana_lectura_if.sv | 29 ++
 rtl/controlador_ventana_lectura_contador_modulo.sv | 23 ++
 rtl/controlador_ventana_lectura.sv | 96 +++++++++
 tb/tb_controlador_ventana_lectura.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/controlador_ventana_lectura_pkg.sv
// Shared definitions for the window read sequencer: FSM state codes and default window geometry.
package controlador_ventana_lectura_pkg;

    localparam logic [2:0] REPOSO  = 3'd0;
    localparam logic [2:0] CARGAR  = 3'd1;
    localparam logic [2:0] LEER    = 3'd2;
    localparam logic [2:0] AVANZAR = 3'd3;
    localparam logic [2:0] FIN     = 3'd4;

    localparam int unsigned BITS_DATOS_DEF       = 18;
    localparam int unsigned FILAS_VENTANA_DEF    = 3;
    localparam int unsigned COLUMNAS_VENTANA_DEF = 3;
    localparam int unsigned BITS_FILA_DEF        = 2;
    localparam int unsigned BITS_COLUMNA_DEF     = 2;

endpackage

// File: rtl/controlador_ventana_lectura_if.sv
// Start/read handshake and address-register control bundle of the window read sequencer.
interface controlador_ventana_lectura_if
    import controlador_ventana_lectura_pkg::*;
#(
    parameter int unsigned BITS_DATOS   = BITS_DATOS_DEF,
    parameter int unsigned BITS_COLUMNA = BITS_COLUMNA_DEF
);
    logic                    iniciar;
    logic [BITS_DATOS-1:0]   base_ventana;
    logic                    lectura_lista;
    logic [BITS_DATOS-1:0]   base;
    logic                    guardar;
    logic                    sumar;
    logic [BITS_COLUMNA-1:0] columna;
    logic                    lectura_valida;
    logic                    ocupado;
    logic                    listo;

    modport master (
        input  iniciar, base_ventana, lectura_lista,
        output base, guardar, sumar, columna, lectura_valida, ocupado, listo
    );

    modport slave (
        output iniciar, base_ventana, lectura_lista,
        input  base, guardar, sumar, columna, lectura_valida, ocupado, listo
    );

endinterface

// File: rtl/controlador_ventana_lectura_contador_modulo.sv
// Small up-counter with synchronous clear (priority) and increment enable.
module contador_modulo #(
    parameter int unsigned ANCHO = 2
)(
    input  logic             clk,
    input  logic             i_limpiar,
    input  logic             i_incrementar,
    output logic [ANCHO-1:0] o_valor
);

    logic [ANCHO-1:0] r_valor;

    always_ff @(posedge clk) begin
        if (i_limpiar) begin
            r_valor <= '0;
        end else if (i_incrementar) begin
            r_valor <= r_valor + 1'b1;
        end
    end

    assign o_valor = r_valor;

endmodule

// File: rtl/controlador_ventana_lectura.sv
// Window read sequencer: loads the row base, issues one read per pixel and steps rows.
// Optional abort input enabled by defining CONTROLADOR_VENTANA_ABORTAR_EN.
module controlador_ventana_lectura
    import controlador_ventana_lectura_pkg::*;
#(
    parameter int unsigned BITS_DATOS       = BITS_DATOS_DEF,
    parameter int unsigned FILAS_VENTANA    = FILAS_VENTANA_DEF,
    parameter int unsigned COLUMNAS_VENTANA = COLUMNAS_VENTANA_DEF,
    parameter int unsigned BITS_FILA        = BITS_FILA_DEF,
    parameter int unsigned BITS_COLUMNA     = BITS_COLUMNA_DEF
)(
    input  logic clk,
    input  logic reset,
`ifdef CONTROLADOR_VENTANA_ABORTAR_EN
    input  logic abortar,
`endif
    controlador_ventana_lectura_if.master bus
);

    logic [2:0]              r_estado;
    logic [2:0]              w_siguiente;
    logic [BITS_DATOS-1:0]   r_base;
    logic [BITS_FILA-1:0]    w_fila;
    logic [BITS_COLUMNA-1:0] w_columna;
    logic                    w_ultima_col;
    logic                    w_ultima_fila;
    logic                    w_transferencia;
    logic                    w_abortar;

    assign w_ultima_col    = (w_columna == BITS_COLUMNA'(COLUMNAS_VENTANA - 1));
    assign w_ultima_fila   = (w_fila == BITS_FILA'(FILAS_VENTANA - 1));
    assign w_transferencia = (r_estado == LEER) && bus.lectura_lista;

`ifdef CONTROLADOR_VENTANA_ABORTAR_EN
    assign w_abortar = abortar &&
                       ((r_estado == CARGAR) || (r_estado == LEER) || (r_estado == AVANZAR));
`else
    assign w_abortar = 1'b0;
`endif

    always_comb begin
        w_siguiente = r_estado;
        case (r_estado)
            REPOSO:  if (bus.iniciar) w_siguiente = CARGAR;
            CARGAR:  w_siguiente = LEER;
            LEER: begin
                if (w_transferencia && w_ultima_col) begin
                    w_siguiente = w_ultima_fila ? FIN : AVANZAR;
                end
            end
            AVANZAR: w_siguiente = LEER;
            FIN:     w_siguiente = REPOSO;
            default: w_siguiente = REPOSO;
        endcase
        if (w_abortar) begin
            w_siguiente = REPOSO;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado <= REPOSO;
            r_base   <= '0;
        end else begin
            r_estado <= w_siguiente;
            if ((r_estado == REPOSO) && bus.iniciar) begin
                r_base <= bus.base_ventana;
            end
        end
    end

    // Counters are also cleared on FIN and abort so an idle controller always shows columna 0.
    contador_modulo #(.ANCHO(BITS_FILA)) u_fila (
        .clk           (clk),
        .i_limpiar     (reset || (r_estado == CARGAR) || (r_estado == FIN) || w_abortar),
        .i_incrementar ((r_estado == AVANZAR) && !w_abortar),
        .o_valor       (w_fila)
    );

    contador_modulo #(.ANCHO(BITS_COLUMNA)) u_columna (
        .clk           (clk),
        .i_limpiar     (reset || (r_estado == CARGAR) || (r_estado == AVANZAR) ||
                        (r_estado == FIN) || w_abortar),
        .i_incrementar (w_transferencia && !w_ultima_col && !w_abortar),
        .o_valor       (w_columna)
    );

    assign bus.base           = r_base;
    assign bus.guardar        = (r_estado == CARGAR);
    assign bus.sumar          = (r_estado == AVANZAR);
    assign bus.columna        = w_columna;
    assign bus.lectura_valida = (r_estado == LEER);
    assign bus.ocupado        = (r_estado != REPOSO);
    assign bus.listo          = (r_estado == FIN);

endmodule

// File: tb/tb_controlador_ventana_lectura.sv
// Randomized self-checking bench for controlador_ventana_lectura against a per-window operation script model.
module tb_controlador_ventana_lectura;

    localparam int F  = 3;
    localparam int C  = 3;
    localparam int BD = 18;

    localparam int K_GUARDAR = 0;
    localparam int K_LEER    = 1;
    localparam int K_SUMAR   = 2;
    localparam int K_LISTO   = 3;

    typedef struct {
        int kind;
        int col;
    } op_t;

    logic clk;
    logic reset;
`ifdef CONTROLADOR_VENTANA_ABORTAR_EN
    logic abortar;
`endif

    controlador_ventana_lectura_if bus ();

    controlador_ventana_lectura dut (
        .clk     (clk),
        .reset   (reset),
`ifdef CONTROLADOR_VENTANA_ABORTAR_EN
        .abortar (abortar),
`endif
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    op_t             q[$];
    logic [BD-1:0]   mbase = '0;
    int n_xfer  = 0;
    int n_sum   = 0;
    int n_listo = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: each accepted start expands into the list of operations the window must perform.
    initial forever begin
        bit ab;
        @(posedge clk);
        ab = 1'b0;
`ifdef CONTROLADOR_VENTANA_ABORTAR_EN
        if (q.size() != 0) ab = abortar && (q[0].kind != K_LISTO);
`endif
        if (reset) begin
            q.delete();
            mbase = '0;
        end else if (q.size() == 0) begin
            if (bus.iniciar) begin
                mbase = bus.base_ventana;
                q.push_back('{K_GUARDAR, 0});
                for (int r = 0; r < F; r++) begin
                    for (int c = 0; c < C; c++) q.push_back('{K_LEER, c});
                    if (r < F - 1) q.push_back('{K_SUMAR, 0});
                end
                q.push_back('{K_LISTO, 0});
            end
        end else if (ab) begin
            q.delete();
        end else if (!(q[0].kind == K_LEER && !bus.lectura_lista)) begin
            void'(q.pop_front());
        end
    end

    initial forever begin
        bit ab;
        @(posedge clk);
        ab = 1'b0;
`ifdef CONTROLADOR_VENTANA_ABORTAR_EN
        ab = abortar;
`endif
        if (!reset) begin
            if (bus.lectura_valida && bus.lectura_lista && !ab) n_xfer++;
            if (bus.sumar) n_sum++;
            if (bus.listo) n_listo++;
        end
    end

    initial forever begin
        int k;
        @(negedge clk);
        if (chk_en) begin
            k = (q.size() != 0) ? q[0].kind : -1;
            chk("guardar", 32'(bus.guardar), 32'(k == K_GUARDAR));
            chk("lectura_valida", 32'(bus.lectura_valida), 32'(k == K_LEER));
            chk("sumar", 32'(bus.sumar), 32'(k == K_SUMAR));
            chk("listo", 32'(bus.listo), 32'(k == K_LISTO));
            chk("ocupado", 32'(bus.ocupado), 32'(q.size() != 0));
            chk("base", 32'(bus.base), 32'(mbase));
            if (k == K_LEER) chk("columna", 32'(bus.columna), 32'(q[0].col));
        end
    end

    // Runs one window from a negedge with the DUT idle; lat is the cycle listo was seen (cycle 0 = accept).
    task automatic window(input logic [BD-1:0] b, input int st_s, input int st_l,
                          input bit hold, output int lat);
        bus.iniciar       = 1'b1;
        bus.base_ventana  = b;
        bus.lectura_lista = 1'b1;
        lat = -1;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(negedge clk);
            if (!hold) bus.iniciar = 1'b0;
            bus.base_ventana = BD'($urandom);
            if (k == 1) begin
                chk("guardar_c1", 32'(bus.guardar), 32'd1);
                chk("base_c1", 32'(bus.base), 32'(b));
            end
            if (bus.listo) lat = k;
            bus.lectura_lista = !(k >= st_s && k < st_s + st_l);
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL listo_timeout: got none expected within 60 cycles");
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.ocupado && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(bus.ocupado), 32'd0);
    endtask

    initial begin
        int lat;
        int s_listo;
        reset             = 1'b1;
        bus.iniciar       = 1'b1;
        bus.base_ventana  = '1;
        bus.lectura_lista = 1'b1;
`ifdef CONTROLADOR_VENTANA_ABORTAR_EN
        abortar = 1'b0;
`endif

        // Reset for two cycles with iniciar high
        @(posedge clk);
        chk_en = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rst_base", 32'(bus.base), 32'd0);
        chk("rst_columna", 32'(bus.columna), 32'd0);
        chk("rst_guardar", 32'(bus.guardar), 32'd0);
        chk("rst_listo", 32'(bus.listo), 32'd0);
        reset = 1'b0;
        bus.iniciar = 1'b0;
        @(negedge clk);
        chk("rst_nostart", 32'(bus.ocupado), 32'd0);

        // Nominal 3x3 window
        n_xfer = 0; n_sum = 0; n_listo = 0;
        window(18'd100, 0, 0, 1'b0, lat);
        @(posedge clk); #1;
        chk("lat_nominal", 32'(lat), 32'd13);
        chk("xfer_nominal", 32'(n_xfer), 32'd9);
        chk("sum_nominal", 32'(n_sum), 32'd2);
        chk("listo_nominal", 32'(n_listo), 32'd1);

        // Backpressure: 4 stall cycles at row 1, column 1 (cycle 7)
        @(negedge clk);
        n_xfer = 0;
        window(18'd200, 7, 4, 1'b0, lat);
        @(posedge clk); #1;
        chk("lat_stall", 32'(lat), 32'd17);
        chk("xfer_stall", 32'(n_xfer), 32'd9);

        // iniciar held high: restart only from REPOSO
        @(negedge clk);
        window(18'd300, 0, 0, 1'b1, lat);
        chk("lat_hold", 32'(lat), 32'd13);
        @(negedge clk);
        chk("hold_c14_idle", 32'(bus.ocupado), 32'd0);
        chk("hold_c14_guardar", 32'(bus.guardar), 32'd0);
        @(negedge clk);
        chk("hold_c15_guardar", 32'(bus.guardar), 32'd1);
        bus.iniciar = 1'b0;
        wait_idle();

        // Reset during stalled read at row 2, column 0 (cycle 10)
        bus.iniciar = 1'b1;
        bus.base_ventana = 18'd400;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus.iniciar = 1'b0;
            bus.lectura_lista = (k < 10);
            if (k == 12) reset = 1'b1;
        end
        s_listo = n_listo;
        @(negedge clk);
        chk("rstmid_ocupado", 32'(bus.ocupado), 32'd0);
        chk("rstmid_valida", 32'(bus.lectura_valida), 32'd0);
        chk("rstmid_base", 32'(bus.base), 32'd0);
        chk("rstmid_columna", 32'(bus.columna), 32'd0);
        reset = 1'b0;
        bus.lectura_lista = 1'b1;
        repeat (20) @(negedge clk);
        chk("rstmid_nolisto", 32'(n_listo - s_listo), 32'd0);
        window(18'd500, 0, 0, 1'b0, lat);
        chk("lat_after_rst", 32'(lat), 32'd13);

`ifdef CONTROLADOR_VENTANA_ABORTAR_EN
        // Abort coinciding with a read transfer
        @(negedge clk);
        s_listo = n_listo;
        n_xfer = 0;
        bus.iniciar = 1'b1;
        bus.base_ventana = 18'd600;
        bus.lectura_lista = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.iniciar = 1'b0;
            abortar = (k == 3);
        end
        @(negedge clk);
        abortar = 1'b0;
        chk("abort_ocupado", 32'(bus.ocupado), 32'd0);
        chk("abort_valida", 32'(bus.lectura_valida), 32'd0);
        chk("abort_xfer", 32'(n_xfer), 32'd1);
        repeat (15) @(negedge clk);
        chk("abort_nolisto", 32'(n_listo - s_listo), 32'd0);
`endif

        // Random traffic checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            bus.iniciar       = ($urandom_range(0, 3) == 0);
            bus.base_ventana  = BD'($urandom);
            bus.lectura_lista = ($urandom_range(0, 2) != 0);
            reset             = ($urandom_range(0, 199) == 0);
`ifdef CONTROLADOR_VENTANA_ABORTAR_EN
            abortar           = ($urandom_range(0, 49) == 0);
`endif
        end
        @(negedge clk);
        reset = 1'b0;
        bus.iniciar = 1'b0;
        bus.lectura_lista = 1'b1;
`ifdef CONTROLADOR_VENTANA_ABORTAR_EN
        abortar = 1'b0;
`endif
        wait_idle();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
